// File: rtl/tapa_ctrl_pkg.sv
// Shared types and constants for the TAPA task control responder.
// State encoding mirrors the slot FSM so traces read the same on both sides.
package tapa_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned DEFAULT_ADDR_WIDTH   = 64;
    localparam int unsigned DEFAULT_CNT_WIDTH    = 64;
    localparam int unsigned DEFAULT_STRIDE_BYTES = 8;

endpackage

// File: rtl/tapa_addr_seq_gen.sv
// Address/index/last sequencer: loads base and n, advances one stride per accepted beat,
// holds otherwise. All outputs are registered.
module tapa_addr_seq_gen
    import tapa_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH    = DEFAULT_CNT_WIDTH,
    parameter int unsigned STRIDE_BYTES = DEFAULT_STRIDE_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [CNT_WIDTH-1:0]  n,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [CNT_WIDTH-1:0]  idx,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  nm1_q, nm1_d;
    logic                  last_q, last_d;
    logic [CNT_WIDTH-1:0]  n_minus1_c;
    logic [CNT_WIDTH-1:0]  idx_inc_c;

    assign n_minus1_c = n - CNT_WIDTH'(1);
    assign idx_inc_c  = idx_q + CNT_WIDTH'(1);

    // Terminal index is n-1 latched at load, so the per-beat compare is a plain equality.
    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
        nm1_d  = nm1_q;
        last_d = last_q;
        if (load) begin
            addr_d = base;
            idx_d  = '0;
            nm1_d  = n_minus1_c;
            last_d = (n_minus1_c == '0);
        end else if (advance) begin
            addr_d = addr_q + ADDR_WIDTH'(STRIDE_BYTES);
            idx_d  = idx_inc_c;
            last_d = (idx_inc_c == nm1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            idx_q  <= '0;
            nm1_q  <= '0;
            last_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
            nm1_q  <= nm1_d;
            last_q <= last_d;
        end
    end

    assign addr = addr_q;
    assign idx  = idx_q;
    assign last = last_q;

endmodule

// File: rtl/tapa_task_ap_ctrl_responder.sv
// Task-side ap_ctrl_hs responder: accepts start+args, streams n address beats, pulses done.
// n==0 completes with ready and done in the accept cycle.
module tapa_task_ap_ctrl_responder
    import tapa_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH    = DEFAULT_CNT_WIDTH,
    parameter int unsigned STRIDE_BYTES = DEFAULT_STRIDE_BYTES
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [ADDR_WIDTH-1:0] mmap_base,
    input  logic [CNT_WIDTH-1:0]  n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [CNT_WIDTH-1:0]  out_idx,
    output logic                  out_last
);

    state_e state_q, state_d;
    logic   accept_c;
    logic   advance_c;
    logic   n_zero_c;

    assign n_zero_c = (n == '0);

    // Next state plus the combinational handshake strobes; reset masks the strobes.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ap_start && !ap_rst) begin
                    accept_c = 1'b1;
                    ap_ready = 1'b1;
                    if (n_zero_c) begin
                        ap_done = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (out_ready && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ap_done = !ap_rst;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ap_idle   = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RUN);
    assign advance_c = out_valid && out_ready;

    tapa_addr_seq_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .STRIDE_BYTES(STRIDE_BYTES)
    ) u_seq (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .load   (accept_c),
        .advance(advance_c),
        .base   (mmap_base),
        .n      (n),
        .addr   (out_addr),
        .idx    (out_idx),
        .last   (out_last)
    );

endmodule

// File: tb/tb_tapa_task_ap_ctrl_responder.sv
// Directed, table-driven bench for tapa_task_ap_ctrl_responder.
module tb_tapa_task_ap_ctrl_responder;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready, ap_done, ap_idle;
    logic [63:0] mmap_base = '0;
    logic [63:0] n = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_addr;
    logic [63:0] out_idx;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    always #5 ap_clk = ~ap_clk;

    tapa_task_ap_ctrl_responder dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .mmap_base(mmap_base),
        .n        (n),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    typedef struct {
        logic        rst, start, rdy;
        logic [63:0] base, n;
        logic        e_ready, e_done, e_idle, e_valid;
        logic        chk_data;
        logic [63:0] e_addr, e_idx;
        logic        e_last;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic rst, logic start, logic rdy, logic [63:0] base, logic [63:0] nn,
                                logic e_ready, logic e_done, logic e_idle, logic e_valid,
                                logic chk_data, logic [63:0] e_addr, logic [63:0] e_idx, logic e_last);
        vec_t v;
        v.rst = rst; v.start = start; v.rdy = rdy; v.base = base; v.n = nn;
        v.e_ready = e_ready; v.e_done = e_done; v.e_idle = e_idle; v.e_valid = e_valid;
        v.chk_data = chk_data; v.e_addr = e_addr; v.e_idx = e_idx; v.e_last = e_last;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs away from the active edge, then let combinational outputs settle.
    task automatic step(input logic rst, input logic start, input logic rdy,
                        input logic [63:0] base, input logic [63:0] nn);
        @(negedge ap_clk);
        ap_rst = rst; ap_start = start; out_ready = rdy; mmap_base = base; n = nn;
        #1;
    endtask

    localparam logic [63:0] WRAP_BASE = 64'hFFFF_FFFF_FFFF_FFF8;

    int done_cnt;
    int valid_cnt;
    bit seen;

    initial begin
        // reset state
        add(1,0,0, 0,0,   0,0,1,0, 1, 0,0,0);
        // n=4, base 0x1000, out_ready=1
        add(0,1,1, 64'h1000,4, 1,0,1,0, 0, 0,0,0);
        add(0,0,1, 64'h1000,4, 0,0,0,1, 1, 64'h1000,0,0);
        add(0,0,1, 64'h1000,4, 0,0,0,1, 1, 64'h1008,1,0);
        add(0,0,1, 64'h1000,4, 0,0,0,1, 1, 64'h1010,2,0);
        add(0,0,1, 64'h1000,4, 0,0,0,1, 1, 64'h1018,3,1);
        add(0,0,1, 64'h1000,4, 0,1,0,0, 0, 0,0,0);
        add(0,0,1, 64'h1000,4, 0,0,1,0, 0, 0,0,0);
        // n=0: ready and done together, stays idle
        add(0,1,1, 64'h3000,0, 1,1,1,0, 0, 0,0,0);
        add(0,0,1, 64'h3000,0, 0,0,1,0, 0, 0,0,0);
        add(0,0,1, 64'h3000,0, 0,0,1,0, 0, 0,0,0);
        // n=3 with out_ready 1,0,0,1,0,1
        add(0,1,0, 64'h4000,3, 1,0,1,0, 0, 0,0,0);
        add(0,0,1, 64'h4000,3, 0,0,0,1, 1, 64'h4000,0,0);
        add(0,0,0, 64'h4000,3, 0,0,0,1, 1, 64'h4008,1,0);
        add(0,0,0, 64'h4000,3, 0,0,0,1, 1, 64'h4008,1,0);
        add(0,0,1, 64'h4000,3, 0,0,0,1, 1, 64'h4008,1,0);
        add(0,0,0, 64'h4000,3, 0,0,0,1, 1, 64'h4010,2,1);
        add(0,0,1, 64'h4000,3, 0,0,0,1, 1, 64'h4010,2,1);
        add(0,0,1, 64'h4000,3, 0,1,0,0, 0, 0,0,0);
        add(0,0,1, 64'h4000,3, 0,0,1,0, 0, 0,0,0);
        // address wrap
        add(0,1,1, WRAP_BASE,2, 1,0,1,0, 0, 0,0,0);
        add(0,0,1, WRAP_BASE,2, 0,0,0,1, 1, WRAP_BASE,0,0);
        add(0,0,1, WRAP_BASE,2, 0,0,0,1, 1, 64'h0,1,1);
        add(0,0,1, WRAP_BASE,2, 0,1,0,0, 0, 0,0,0);
        add(0,0,1, WRAP_BASE,2, 0,0,1,0, 0, 0,0,0);
        // ap_start held through RUN and DONE, re-accepted on return to IDLE
        add(0,1,1, 64'h2000,2, 1,0,1,0, 0, 0,0,0);
        add(0,1,1, 64'h2000,2, 0,0,0,1, 1, 64'h2000,0,0);
        add(0,1,1, 64'h2000,2, 0,0,0,1, 1, 64'h2008,1,1);
        add(0,1,1, 64'h2000,2, 0,1,0,0, 0, 0,0,0);
        add(0,1,1, 64'h2000,2, 1,0,1,0, 0, 0,0,0);
        add(0,0,1, 64'h2000,2, 0,0,0,1, 1, 64'h2000,0,0);
        add(0,0,1, 64'h2000,2, 0,0,0,1, 1, 64'h2008,1,1);
        add(0,0,1, 64'h2000,2, 0,1,0,0, 0, 0,0,0);
        add(0,0,1, 64'h2000,2, 0,0,1,0, 0, 0,0,0);

        repeat (2) @(posedge ap_clk);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].start, vq[i].rdy, vq[i].base, vq[i].n);
            chk($sformatf("v%0d_ap_ready", i), 64'(ap_ready), 64'(vq[i].e_ready));
            chk($sformatf("v%0d_ap_done", i), 64'(ap_done), 64'(vq[i].e_done));
            chk($sformatf("v%0d_ap_idle", i), 64'(ap_idle), 64'(vq[i].e_idle));
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vq[i].e_valid));
            if (vq[i].chk_data) begin
                chk($sformatf("v%0d_out_addr", i), out_addr, vq[i].e_addr);
                chk($sformatf("v%0d_out_idx", i), out_idx, vq[i].e_idx);
                chk($sformatf("v%0d_out_last", i), 64'(out_last), 64'(vq[i].e_last));
            end
        end

        // reset after beat 1 of n=5: partial stream abandoned, no done
        step(0,1,1, 64'h5000,5);
        chk("rst_accept", 64'(ap_ready), 64'd1);
        step(0,0,1, 64'h5000,5);
        chk("rst_beat0_addr", out_addr, 64'h5000);
        step(1,0,1, 64'h5000,5);
        chk("rst_beat1_idx", out_idx, 64'd1);
        chk("rst_cycle_done", 64'(ap_done), 64'd0);
        step(0,0,1, 64'h5000,5);
        chk("post_rst_idle", 64'(ap_idle), 64'd1);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_done", 64'(ap_done), 64'd0);
        done_cnt = 0; valid_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(0,0,1, 64'h5000,5);
            if (ap_done) done_cnt++;
            if (out_valid) valid_cnt++;
        end
        chk("post_rst_quiet_done", 64'(done_cnt), 64'd0);
        chk("post_rst_quiet_valid", 64'(valid_cnt), 64'd0);

        // fresh n=1 run after the reset, done awaited under a cycle budget
        step(0,1,1, 64'h6000,1);
        chk("n1_accept", 64'(ap_ready), 64'd1);
        step(0,0,1, 64'h6000,1);
        chk("n1_valid", 64'(out_valid), 64'd1);
        chk("n1_addr", out_addr, 64'h6000);
        chk("n1_idx", out_idx, 64'd0);
        chk("n1_last", 64'(out_last), 64'd1);
        done_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(0,0,1, 64'h6000,1);
            if (ap_done) begin
                done_cnt++;
                seen = 1'b1;
            end
        end
        chk("n1_done_seen", 64'(seen), 64'd1);
        chk("n1_done_count", 64'(done_cnt), 64'd1);
        chk("n1_final_idle", 64'(ap_idle), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
